// File: rtl/transform_pkg.sv
// transform_pkg
// Shared definitions for the object/world transformation stages.
//   COORD_W          : width of the internal two's complement datapath
//   FIXED_ONE        : fixed-point scale of the sin/cos operands (x1000)
//   LATENCY          : accept edge to out_valid, in cycles
//   DIV_ITERS        : quotient bits produced by the iterative divider
//   state_t          : FSM states of the inverse stage
//   div_by_fixed_one : sign-magnitude, truncate-toward-zero divide by FIXED_ONE
package transform_pkg;

  localparam int COORD_W   = 21;
  localparam int FIXED_ONE = 1000;
  localparam int LATENCY   = 73;
  localparam int DIV_ITERS = 21;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    SUB_T,
    ROT_Y,
    ROT_X,
    ROT_Z,
    DIV,
    DONE
  } state_t;

  // Dividing the magnitude and restoring the sign makes the result truncate
  // toward zero (-7070/1000 = -7), unlike an arithmetic shift or floor divide.
  function automatic coord_t div_by_fixed_one(input coord_t a);
    coord_t mag;
    coord_t q;
    mag = a[COORD_W-1] ? coord_t'(-a) : a;
    q   = mag / coord_t'(FIXED_ONE);
    return a[COORD_W-1] ? coord_t'(-q) : q;
  endfunction

endpackage

// File: rtl/inverse_transformation_if.sv
// inverse_transformation_if
// Operand and result bundle of the inverse transformation stage.
//   in_valid/in_ready   : operand handshake (producer -> stage)
//   Xw..Zw, Tx..Tz      : world point and translation, SIZE+1 bits
//   Sx..Sz              : per-axis scale, SIZE+1 bits
//   sinR*/cosR*         : rotation operands, fixed point x1000, 21 bits
//   out_valid/out_ready : result handshake (stage -> consumer)
//   Xo..Zo, div_zero    : object-space point and per-axis zero-scale flags
// Modport master is the producer/consumer side, slave is the stage itself.
interface inverse_transformation_if #(
  parameter int SIZE        = 9,
  parameter int OUTPUT_SIZE = 9
);
  import transform_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [SIZE:0]        Xw, Yw, Zw;
  logic [SIZE:0]        Tx, Ty, Tz;
  logic [SIZE:0]        Sx, Sy, Sz;
  coord_t               sinRx, cosRx, sinRy, cosRy, sinRz, cosRz;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUTPUT_SIZE:0] Xo, Yo, Zo;
  logic [2:0]           div_zero;

  modport master (
    output in_valid, Xw, Yw, Zw, Tx, Ty, Tz, Sx, Sy, Sz,
           sinRx, cosRx, sinRy, cosRy, sinRz, cosRz, out_ready,
    input  in_ready, out_valid, Xo, Yo, Zo, div_zero
  );

  modport slave (
    input  in_valid, Xw, Yw, Zw, Tx, Ty, Tz, Sx, Sy, Sz,
           sinRx, cosRx, sinRy, cosRy, sinRz, cosRz, out_ready,
    output in_ready, out_valid, Xo, Yo, Zo, div_zero
  );

endinterface

// File: rtl/signed_divider.sv
// signed_divider
// Iterative restoring divider on 21-bit two's complement operands.
//   clk, reset : clock and synchronous active-high reset
//   start      : load dividend/divisor (ignored while busy)
//   dividend   : numerator
//   divisor    : denominator; zero yields quotient 0 and div_zero=1
//   busy       : an operation is in flight
//   done       : one-cycle strobe, quotient/div_zero valid this cycle
//   quotient   : sign-magnitude quotient, truncated toward zero
//   div_zero   : divisor of the current operation was zero
// Timing: start cycle, then 21 cycles; the last of these has done=1.
module signed_divider
  import transform_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   start,
  input  coord_t dividend,
  input  coord_t divisor,
  output logic   busy,
  output logic   done,
  output coord_t quotient,
  output logic   div_zero
);

  coord_t     rem;
  coord_t     quo;
  coord_t     dvs;
  logic       neg;
  logic       zero;
  logic [4:0] cnt;

  logic [COORD_W:0] trial;
  logic             ge;
  coord_t           diff;
  coord_t           rem_next;
  coord_t           quo_next;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor when it fits. The 21st step is
  // never registered; it feeds the quotient output directly during the
  // done cycle so the caller captures it on that same edge.
  always_comb begin
    trial    = {rem, quo[COORD_W-1]};
    ge       = (trial >= {1'b0, dvs});
    diff     = trial[COORD_W-1:0] - dvs;
    rem_next = ge ? diff : trial[COORD_W-1:0];
    quo_next = {quo[COORD_W-2:0], ge};
  end

  assign done     = busy && (cnt == 5'(DIV_ITERS - 1));
  assign quotient = zero ? '0 : (neg ? coord_t'(-quo_next) : quo_next);
  assign div_zero = zero;

  // Operands are turned into magnitudes at start; the sign is reapplied to
  // the final quotient, which gives truncation toward zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
      neg  <= 1'b0;
      zero <= 1'b0;
    end else if (start && !busy) begin
      busy <= 1'b1;
      cnt  <= '0;
      rem  <= '0;
      quo  <= dividend[COORD_W-1] ? coord_t'(-dividend) : dividend;
      dvs  <= divisor[COORD_W-1] ? coord_t'(-divisor) : divisor;
      neg  <= dividend[COORD_W-1] ^ divisor[COORD_W-1];
      zero <= (divisor == '0);
    end else if (busy) begin
      if (done) begin
        busy <= 1'b0;
      end else begin
        rem <= rem_next;
        quo <= quo_next;
        cnt <= cnt + 5'd1;
      end
    end
  end

endmodule

// File: rtl/inverse_transformation.sv
// inverse_transformation
// Maps a world-space point back to object space: subtract translation,
// rotate by -Ry, -Rx, -Rz, then divide each axis by its scale.
//   clk   : clock, all logic on the rising edge
//   reset : synchronous, active-high
//   bus   : inverse_transformation_if.slave (operands, result, handshakes)
// One operation at a time; out_valid rises 73 cycles after the accept edge.
module inverse_transformation
  import transform_pkg::*;
#(
  parameter int SIZE        = 9,
  parameter int OUTPUT_SIZE = 9
) (
  input logic clk,
  input logic reset,
  inverse_transformation_if.slave bus
);

  state_t state;
  state_t state_next;

  coord_t xw_r, yw_r, zw_r;
  coord_t tx_r, ty_r, tz_r;
  coord_t sx_r, sy_r, sz_r;
  coord_t srx, crx, sry, cry, srz, crz;

  coord_t x, y, z;
  coord_t tmp;
  logic   phase;
  logic [1:0] axis;

  logic [OUTPUT_SIZE:0] xo, yo, zo;
  logic [2:0]           dz;

  coord_t rot_p, rot_q, rot_c1, rot_c2;
  coord_t rot_sum;
  coord_t rot_res;

  logic   div_start;
  logic   div_busy;
  logic   div_done;
  logic   div_zf;
  coord_t div_a;
  coord_t div_b;
  coord_t div_q;

  function automatic coord_t sext(input logic [SIZE:0] v);
    return {{(COORD_W-SIZE-1){v[SIZE]}}, v};
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state. Each rotation spends two cycles (phase 0 then 1); the
  // division phase ends when the third axis reports done.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = SUB_T;
      SUB_T:   state_next = ROT_Y;
      ROT_Y:   if (phase) state_next = ROT_X;
      ROT_X:   if (phase) state_next = ROT_Z;
      ROT_Z:   if (phase) state_next = DIV;
      DIV:     if (div_done && axis == 2'd2) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Rotation operand select. Phase 0 computes the first coordinate of the
  // pair, phase 1 the second; both read the pre-step values because the
  // phase-0 result waits in tmp until phase 1.
  always_comb begin
    rot_p  = '0;
    rot_q  = '0;
    rot_c1 = '0;
    rot_c2 = '0;
    case (state)
      ROT_Y: begin
        rot_p = x;
        rot_q = z;
        if (!phase) begin
          rot_c1 = cry;
          rot_c2 = coord_t'(-sry);
        end else begin
          rot_c1 = sry;
          rot_c2 = cry;
        end
      end
      ROT_X: begin
        rot_p = y;
        rot_q = z;
        if (!phase) begin
          rot_c1 = crx;
          rot_c2 = srx;
        end else begin
          rot_c1 = coord_t'(-srx);
          rot_c2 = crx;
        end
      end
      ROT_Z: begin
        rot_p = x;
        rot_q = y;
        if (!phase) begin
          rot_c1 = crz;
          rot_c2 = srz;
        end else begin
          rot_c1 = coord_t'(-srz);
          rot_c2 = crz;
        end
      end
      default: ;
    endcase
    rot_sum = (rot_p * rot_c1) + (rot_q * rot_c2);
    rot_res = div_by_fixed_one(rot_sum);
  end

  // Divider feed: one axis at a time, restarted whenever it is idle while
  // in DIV, which gives a fixed 22 cycles per axis.
  always_comb begin
    div_start = (state == DIV) && !div_busy;
    case (axis)
      2'd0:    begin div_a = x; div_b = sx_r; end
      2'd1:    begin div_a = y; div_b = sy_r; end
      default: begin div_a = z; div_b = sz_r; end
    endcase
  end

  signed_divider u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (div_a),
    .divisor  (div_b),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q),
    .div_zero (div_zf)
  );

  // Datapath: operand capture, translation, rotations and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      xw_r <= '0; yw_r <= '0; zw_r <= '0;
      tx_r <= '0; ty_r <= '0; tz_r <= '0;
      sx_r <= '0; sy_r <= '0; sz_r <= '0;
      srx  <= '0; crx  <= '0; sry  <= '0;
      cry  <= '0; srz  <= '0; crz  <= '0;
      x    <= '0; y    <= '0; z    <= '0;
      tmp  <= '0;
      phase <= 1'b0;
      axis  <= '0;
      xo    <= '0; yo <= '0; zo <= '0;
      dz    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            xw_r <= sext(bus.Xw); yw_r <= sext(bus.Yw); zw_r <= sext(bus.Zw);
            tx_r <= sext(bus.Tx); ty_r <= sext(bus.Ty); tz_r <= sext(bus.Tz);
            sx_r <= sext(bus.Sx); sy_r <= sext(bus.Sy); sz_r <= sext(bus.Sz);
            srx  <= bus.sinRx; crx <= bus.cosRx;
            sry  <= bus.sinRy; cry <= bus.cosRy;
            srz  <= bus.sinRz; crz <= bus.cosRz;
            phase <= 1'b0;
            axis  <= '0;
            dz    <= '0;
          end
        end
        SUB_T: begin
          x <= xw_r - tx_r;
          y <= yw_r - ty_r;
          z <= zw_r - tz_r;
        end
        ROT_Y, ROT_X, ROT_Z: begin
          if (!phase) begin
            tmp   <= rot_res;
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            case (state)
              ROT_Y:   begin x <= tmp; z <= rot_res; end
              ROT_X:   begin y <= tmp; z <= rot_res; end
              default: begin x <= tmp; y <= rot_res; end
            endcase
          end
        end
        DIV: begin
          if (div_done) begin
            case (axis)
              2'd0:    begin xo <= div_q[OUTPUT_SIZE:0]; dz[0] <= div_zf; end
              2'd1:    begin yo <= div_q[OUTPUT_SIZE:0]; dz[1] <= div_zf; end
              default: begin zo <= div_q[OUTPUT_SIZE:0]; dz[2] <= div_zf; end
            endcase
            axis <= (axis == 2'd2) ? 2'd0 : axis + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.Xo        = xo;
  assign bus.Yo        = yo;
  assign bus.Zo        = zo;
  assign bus.div_zero  = dz;

endmodule

// File: doc/inverse_transformation.md
# inverse_transformation

Sequential inverse of the object-to-world 3D transformation stage: takes a world-space point plus the same translation, scale and sin/cos rotation operands the forward stage uses and recovers the object-space point. Undoes the forward order: subtract translation, rotate by −Ry, −Rx, −Rz, then divide by scale. Used for picking and hit-testing: a screen/world point is mapped back into model space. One shared iterative divider keeps area small; operation is multi-cycle with valid/ready handshakes on both sides.

## Interface
- SIZE, 9: MSB index of world coordinate, translation and scale inputs (SIZE+1 bits).
- OUTPUT_SIZE, 9: MSB index of object-space outputs.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block idle, accepts operands.
- Xw, Yw, Zw  in  SIZE+1  world point, two's complement.
- Tx, Ty, Tz  in  SIZE+1  translation, two's complement.
- Sx, Sy, Sz  in  SIZE+1  scale, two's complement.
- sinRx, cosRx, sinRy, cosRy, sinRz, cosRz  in  21  fixed-point ×1000, two's complement.
- out_valid  out  1  result valid; held until taken.
- out_ready  in  1  consumer accepts result.
- Xo, Yo, Zo  out  OUTPUT_SIZE+1  object-space point.
- div_zero  out  3  per-axis flag {z,y,x}: that scale was 0.

## Operation
- All inputs sampled into registers on the accept edge (in_valid && in_ready); later input changes ignored.
- Internal datapath 21-bit two's complement; inputs sign-extended; intermediate overflow wraps mod 2^21.
- FSM: IDLE → SUB_T → ROT_Y (2 cycles) → ROT_X (2) → ROT_Z (2) → DIV (3 × 22 cycles) → DONE → IDLE.
- SUB_T: X=Xw−Tx, Y=Yw−Ty, Z=Zw−Tz.
- ROT_Y: X'=(X·cosRy − Z·sinRy)/1000, Z'=(X·sinRy + Z·cosRy)/1000; one coordinate per cycle, both from pre-step values.
- ROT_X: Y'=(Y·cosRx + Z·sinRx)/1000, Z'=(−Y·sinRx + Z·cosRx)/1000.
- ROT_Z: X'=(X·cosRz + Y·sinRz)/1000, Y'=(−X·sinRz + Y·cosRz)/1000.
- Division by 1000 and by scale: sign-magnitude, truncate toward zero (−7/3 = −2).
- DIV: X, Y, Z divided by Sx, Sy, Sz in sequence; each is 1 start cycle + 21 iteration cycles.
- Scale 0: divider still runs (constant latency); quotient forced to 0, matching div_zero bit set.
- Outputs = low OUTPUT_SIZE+1 bits of 21-bit results (wrap, no saturation).
- DONE: out_valid=1; Xo/Yo/Zo/div_zero stable. On out_valid && out_ready → IDLE.
- No overlap: in_ready=1 only in IDLE.

## Timing
- Reset: state IDLE, in_ready=1, out_valid=0, Xo=Yo=Zo=0, div_zero=0, divider idle.
- Reset mid-operation: abandons computation, same values next cycle; no result emitted.
- Latency: out_valid rises exactly 73 cycles after the accept edge (1+2+2+2+66).
- in_ready falls the cycle after accept; rises the cycle after the output handshake edge.
- out_ready asserted while not out_valid: ignored.
- Simultaneous in_valid during DONE: not accepted until back in IDLE.

## Structure
- Package transform_pkg: COORD_W=21, FIXED_ONE=1000, state enum, LATENCY=73, sign-magnitude divide-by-constant function shared with the forward stage.
- Sub-module signed_divider: 21-bit restoring divider, start/done, sign-magnitude truncating, divide-by-zero returns 0 plus flag.

## Test plan
- Identity (sin=0, cos=1000, T=0, S=1), in (5,−3,7) → out (5,−3,7), div_zero=0, out_valid at cycle 73.
- T=(10,20,−5), S=(2,3,1), identity rotation, in (30,29,−5) → (10,3,0).
- sinRz=1000, cosRz=0, others identity, T=0, S=1, in (0,4,0) → (4,0,0); same with Rx 90°, in (0,0,4) → (0,4,0).
- S=(3,1,0), identity otherwise, in (−7,2,9) → (−2,2,0), div_zero=3'b100.
- out_ready low 5 cycles after out_valid → outputs held, in_ready low; new in_valid ignored until handshake + 1 cycle.
- reset asserted at cycle 30 of an operation → next cycle IDLE, out_valid=0, outputs 0; next accepted operand set yields a correct result 73 cycles later.
